// File: rtl/spi_nibble_master.sv
// SPI initiator reading LSB-first 4-bit words from a nibble responder.
// Define SPI_NIBBLE_GAP_EN to insert one unsampled SCK period between nibbles.
module spi_nibble_master #(
  parameter int CLK_DIV = 4,
  parameter int NIBBLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] tx_nibble,
  output logic       busy,
  output logic       done,
  output logic [3:0] rx_word,
  output logic       rx_valid,
  output logic [3:0] rx_count,
  output logic       SSEL,
  output logic       SCK,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [3:0]    NIB_LAST = 4'(NIBBLES);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, HOLD, RECOVER} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          half_q, half_d;
  logic [1:0]    bit_q, bit_d;
  logic [3:0]    nib_q, nib_d;
  logic [3:0]    tx_q, tx_d;
  logic [3:0]    sr_q, sr_d;
  logic          pend_q, pend_d;
  logic          busy_d, done_d, ssel_d, sck_d, mosi_d;
  logic [3:0]    rx_word_d, rx_count_d;
  logic          rx_valid_d;
  logic          cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      half_q   <= 1'b0;
      bit_q    <= 2'd0;
      nib_q    <= 4'd0;
      tx_q     <= 4'd0;
      sr_q     <= 4'd0;
      pend_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      SSEL     <= 1'b1;
      SCK      <= 1'b0;
      MOSI     <= 1'b0;
      rx_word  <= 4'd0;
      rx_valid <= 1'b0;
      rx_count <= 4'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      bit_q    <= bit_d;
      nib_q    <= nib_d;
      tx_q     <= tx_d;
      sr_q     <= sr_d;
      pend_q   <= pend_d;
      busy     <= busy_d;
      done     <= done_d;
      SSEL     <= ssel_d;
      SCK      <= sck_d;
      MOSI     <= mosi_d;
      rx_word  <= rx_word_d;
      rx_valid <= rx_valid_d;
      rx_count <= rx_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_last ? '0 : cnt_q + 1'b1;
    half_d     = half_q;
    bit_d      = bit_q;
    nib_d      = nib_q;
    tx_d       = tx_q;
    sr_d       = sr_q;
    pend_d     = 1'b0;
    busy_d     = busy;
    done_d     = 1'b0;
    ssel_d     = SSEL;
    mosi_d     = MOSI;
    rx_word_d  = rx_word;
    rx_valid_d = 1'b0;
    rx_count_d = rx_count;

    // Nibble completes one cycle after its fourth sample is registered.
    if (pend_q) begin
      rx_word_d  = sr_q;
      rx_valid_d = 1'b1;
      if (rx_count != NIB_LAST)
        rx_count_d = rx_count + 4'd1;
    end

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        half_d = 1'b0;
        if (start) begin
          state_d    = SETUP;
          tx_d       = tx_nibble;
          rx_count_d = 4'd0;
          busy_d     = 1'b1;
          ssel_d     = 1'b0;
          mosi_d     = tx_nibble[0];
          bit_d      = 2'd0;
          nib_d      = 4'd0;
        end
      end
      SETUP: begin
        if (cnt_last) begin
          half_d = ~half_q;
          if (half_q)
            state_d = SHIFT;
        end
      end
      SHIFT, GAP: begin
        if (cnt_last) begin
          half_d = ~half_q;
          if (!half_q) begin
            // SCK rising: sample only in data slots.
            if (state_q == SHIFT) begin
              sr_d   = {MISO, sr_q[3:1]};
              pend_d = (bit_q == 2'd3);
            end
          end else if (state_q == GAP) begin
            state_d = SHIFT;
            mosi_d  = tx_q[0];
          end else begin
            bit_d  = bit_q + 2'd1;
            mosi_d = tx_q[bit_d];
            if (bit_q == 2'd3) begin
              nib_d = nib_q + 4'd1;
              if (nib_d == NIB_LAST) begin
                state_d = HOLD;
                mosi_d  = 1'b0;
              end else begin
`ifdef SPI_NIBBLE_GAP_EN
                state_d = GAP;
                mosi_d  = 1'b0;
`endif
              end
            end
          end
        end
      end
      HOLD: begin
        if (cnt_last) begin
          state_d = RECOVER;
          ssel_d  = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      RECOVER: begin
        if (cnt_last)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    sck_d = half_d && (state_d == SHIFT || state_d == GAP);
  end

endmodule

// File: tb/tb_spi_nibble_master.sv
// Bench for spi_nibble_master: cycle-indexed frame model, behavioural responder, literal frame pins.
module tb_spi_nibble_master;
  localparam int D = 4;
  localparam int N = 4;
`ifdef SPI_NIBBLE_GAP_EN
  localparam int G       = 1;
  localparam int L_RISE  = 19;
  localparam int L_DONE  = 165;
  localparam int L_LEN   = 164;
  localparam int L_MOSI6 = 32'h318C6;
`else
  localparam int G       = 0;
  localparam int L_RISE  = 16;
  localparam int L_DONE  = 141;
  localparam int L_LEN   = 140;
  localparam int L_MOSI6 = 32'h6666;
`endif
  localparam int P  = 4 + G;
  localparam int S  = 4 * N + G * (N - 1);
  localparam int T0 = 1 + 2 * D;
  localparam int TE = T0 + 2 * D * S;
  localparam int TD = TE + D;
  localparam int TI = TD + D;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, MISO = 1'b0;
  logic [3:0] tx_nibble = 4'd0;
  logic busy, done, rx_valid, SSEL, SCK, MOSI;
  logic [3:0] rx_word, rx_count;

  always #5 clk = ~clk;

  spi_nibble_master #(.CLK_DIV(D), .NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_nibble(tx_nibble),
    .busy(busy), .done(done), .rx_word(rx_word), .rx_valid(rx_valid),
    .rx_count(rx_count), .SSEL(SSEL), .SCK(SCK), .MOSI(MOSI), .MISO(MISO)
  );

  int total = 0, bad = 0;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  logic [3:0] resp [N];

  // Frame shape as a function of cycles since start was accepted.
  function automatic bit f_sck(input int c);
    return (c >= T0) && (c < TE) && (((c - T0) % (2 * D)) >= D);
  endfunction
  function automatic bit f_mosi(input int c, input logic [3:0] tx);
    int b;
    if (c >= 1 && c < T0) return tx[0];
    if (c < T0 || c >= TE) return 1'b0;
    b = ((c - T0) / (2 * D)) % P;
    if (b == 4) return 1'b0;
    return tx[b];
  endfunction
  function automatic bit f_rxv(input int c);
    int o;
    o = c - T0 - D - 1;
    if (c < T0 || o < 0 || (o % (2 * D)) != 0) return 1'b0;
    return ((o / (2 * D)) < S) && (((o / (2 * D)) % P) == 3);
  endfunction

  int fc = -1;
  int exp_cnt = 0;
  logic [3:0] exp_word = 4'd0;
  logic [3:0] m_tx = 4'd0;

  always @(posedge clk) begin
    int n;
    if (rst) begin
      fc <= -1; exp_cnt <= 0; exp_word <= 4'd0;
    end else begin
      if ((fc < 1 || fc >= TI) && start) n = 1;
      else if (fc >= 1 && fc < TI)       n = fc + 1;
      else                               n = -1;
      fc <= n;
      if (n == 1) begin
        m_tx <= tx_nibble; exp_cnt <= 0;
      end else if (f_rxv(n)) begin
        exp_word <= resp[((n - T0) / (2 * D)) / P];
        exp_cnt  <= (exp_cnt < N) ? exp_cnt + 1 : exp_cnt;
      end
    end
  end

  // Responder: one slot per SCK period, advancing on each SCK fall.
  int k = 0;
  logic r_psck = 1'b0;
  always @(negedge clk) begin
    int kn, nb, b;
    if (SSEL) kn = 0;
    else if (r_psck && !SCK) kn = k + 1;
    else kn = k;
    k <= kn;
    r_psck <= SCK;
    nb = kn / P; b = kn % P;
    if (nb >= N)     MISO <= 1'b0;
    else if (b == 4) MISO <= 1'b1;
    else             MISO <= resp[nb][b];
  end

  bit chk_en = 1'b0;
  int n_rise = 0, ssel_lo = 0, n_done = 0;
  logic [31:0] mosi_bits = '0;
  logic [3:0] rxq [$];
  logic m_psck = 1'b0;

  always @(negedge clk) if (chk_en) begin
    chk("SSEL",     int'(SSEL),     int'(!(fc >= 1 && fc < TD)));
    chk("busy",     int'(busy),     int'(fc >= 1 && fc < TD));
    chk("done",     int'(done),     int'(fc == TD));
    chk("SCK",      int'(SCK),      int'(f_sck(fc)));
    chk("MOSI",     int'(MOSI),     int'(f_mosi(fc, m_tx)));
    chk("rx_valid", int'(rx_valid), int'(f_rxv(fc)));
    chk("rx_count", int'(rx_count), exp_cnt);
    chk("rx_word",  int'(rx_word),  int'(exp_word));
    if (SCK && !m_psck) begin
      n_rise <= n_rise + 1;
      mosi_bits <= {mosi_bits[30:0], MOSI};
    end
    m_psck <= SCK;
    if (!SSEL) ssel_lo <= ssel_lo + 1;
    if (done) n_done <= n_done + 1;
    if (rx_valid) rxq.push_back(rx_word);
  end

  task automatic run_frame(input logic [3:0] tx, input logic [3:0] d0, d1, d2, d3,
                           input bit poke);
    int r0, s0, q0, dcyc;
    resp[0] = d0; resp[1] = d1; resp[2] = d2; resp[3] = d3;
    tx_nibble = tx;
    r0 = n_rise; s0 = ssel_lo; q0 = rxq.size(); dcyc = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 1; c < 1000; c++) begin
      if (done) begin dcyc = c; break; end
      if (poke && c == 50) start = 1'b1;
      else if (poke && c == 51) start = 1'b0;
      @(negedge clk);
    end
    if (poke) begin
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    repeat (D + 3) @(negedge clk);
    chk("done cycle", dcyc, L_DONE);
    chk("sck rises", n_rise - r0, L_RISE);
    chk("frame len", ssel_lo - s0, L_LEN);
    chk("rx strobes", rxq.size() - q0, 4);
    if (rxq.size() - q0 == 4) begin
      chk("rx w0", int'(rxq[q0]),     int'(d0));
      chk("rx w1", int'(rxq[q0 + 1]), int'(d1));
      chk("rx w2", int'(rxq[q0 + 2]), int'(d2));
      chk("rx w3", int'(rxq[q0 + 3]), int'(d3));
    end
    chk("final rx_count", int'(rx_count), 4);
    if (tx == 4'h6)
      chk("mosi bits", int'(mosi_bits & ((32'd1 << L_RISE) - 32'd1)), L_MOSI6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int q0, nd, w;
    rst = 1'b1;
    @(posedge clk) chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("reset SSEL", int'(SSEL), 1);
    chk("reset SCK",  int'(SCK),  0);
    chk("reset MOSI", int'(MOSI), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset strobes", n_done + rxq.size(), 0);

    run_frame(4'h0, 4'hF, 4'h1, 4'h2, 4'h3, 1'b0);
    run_frame(4'h6, 4'hA, 4'h5, 4'hC, 4'h3, 1'b1);

    // Reset after the second received nibble.
    resp[0] = 4'hF; resp[1] = 4'h1; resp[2] = 4'h2; resp[3] = 4'h3;
    tx_nibble = 4'h9;
    q0 = rxq.size(); nd = n_done;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    w = 0;
    while (rxq.size() - q0 < 2 && w < 400) begin @(negedge clk); w++; end
    chk("rx before reset", rxq.size() - q0 >= 2 ? 1 : 0, 1);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("midrst SSEL",     int'(SSEL),     1);
    chk("midrst SCK",      int'(SCK),      0);
    chk("midrst rx_count", int'(rx_count), 0);
    chk("midrst busy",     int'(busy),     0);
    repeat (200) @(negedge clk);
    chk("no done after reset", n_done - nd, 0);

    run_frame(4'h9, 4'hF, 4'h1, 4'h2, 4'h3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_nibble_master.md
# spi_nibble_master

SPI initiator that clocks 4-bit words in from the FPGA's nibble-oriented SPI responder, such as the LSB-first nibble counter. It drives SSEL/SCK/MOSI, samples MISO, and presents each received nibble with a one-cycle valid strobe. It is used on-chip for loopback self-test of the responder, and as the reader side when the FPGA talks to nibble-protocol peripherals.

## Interface
- CLK_DIV, 4: SCK half-period in clk cycles; legal range ≥4, which covers the responder's 2-FF edge detect plus its output register.
- NIBBLES, 4: nibbles per frame; legal range 1..15.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- tx_nibble  in  4  word shifted out on MOSI, LSB first, repeated for every nibble; captured at start.
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses.
- done  out  1  one-cycle pulse at end of frame.
- rx_word  out  4  last received nibble; first-sampled bit lands in bit 0.
- rx_valid  out  1  one-cycle pulse when rx_word updates.
- rx_count  out  4  number of nibbles received in the current frame.
- SSEL  out  1  active-low select.
- SCK  out  1  idles low.
- MOSI  out  1  serial data out.
- MISO  in  1  serial data in; may be Z during the gap slot.

## Operation
- States: IDLE, SETUP, SHIFT, GAP, HOLD, RECOVER.
- IDLE: SSEL=1, SCK=0. If start=1, capture tx_nibble, clear rx_count, assert busy and SSEL=0 on the next cycle, then enter SETUP.
- SETUP: hold SSEL=0 and SCK=0 for 2*CLK_DIV cycles; drive MOSI with bit 0.
- SHIFT: each bit is SCK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - MISO is registered on the cycle SCK goes 0→1.
  - MOSI advances to the next bit on the cycle SCK goes 1→0.
  - After 4 sampled bits, rx_word is loaded and rx_valid pulses one cycle later; rx_count increments in the same cycle, saturating at NIBBLES.
- After the last bit of nibble N:
  - if N<NIBBLES: go to GAP (macro defined) or back to SHIFT (macro undefined);
  - if N=NIBBLES: go to HOLD.
- GAP: one full SCK period, same shape as a bit period. MISO is not sampled and MOSI is held at 0.
- HOLD: SCK low for CLK_DIV cycles, then SSEL=1. done pulses in the same cycle SSEL rises, and busy drops in that cycle.
- RECOVER: SSEL stays high for CLK_DIV cycles before returning to IDLE. start is ignored in RECOVER and whenever busy=1.
- Arithmetic: a $clog2(CLK_DIV) divider counter, a 2-bit bit index that wraps 3→0, and a 4-bit nibble counter. No outputs are ever X.

## Timing
- Reset values: SSEL=1, SCK=0, MOSI=0, busy=0, done=0, rx_valid=0, rx_word=0, rx_count=0, state=IDLE.
- Latency from start to SSEL low is 1 cycle.
- Latency from start to first SCK rise is 1+3*CLK_DIV cycles.
- Frame length from SSEL fall to SSEL rise:
  - 2*CLK_DIV + NIBBLES*4*2*CLK_DIV + G*2*CLK_DIV + CLK_DIV cycles;
  - G = NIBBLES-1 with the macro defined, otherwise 0.
- For CLK_DIV=4, NIBBLES=4 with the macro defined: 8+128+24+4 = 164 cycles.
- rst=1 mid-frame: on the next cycle SSEL=1, SCK=0, all outputs return to reset values, and no done pulses.
- start=1 in the same cycle as rst=1 is ignored.

## Configuration
- SPI_NIBBLE_GAP_EN
  - Defined: one unsampled SCK period (GAP) is inserted between consecutive nibbles, matching the responder's high-impedance marker slot. No gap is inserted after the last nibble.
  - Undefined: nibbles are clocked back-to-back, 4*NIBBLES SCK periods in total, for responders without a marker slot.

## Test plan
- Reset: hold rst 3 cycles, then release with start=0 for 20 cycles → SSEL=1, SCK=0, MOSI=0, busy=0, and no strobes.
- Loopback against the counter responder, CLK_DIV=4, NIBBLES=4, macro defined, single start pulse:
  - rx_valid pulses 4 times with rx_word = 0xF, 0x1, 0x2, 0x3;
  - 19 SCK rising edges;
  - done pulses at cycle 165 after start;
  - rx_count=4.
- Same setup with the macro undefined, against a behavioural responder with no gap sending 0xA,0x5,0xC,0x3:
  - rx_word sequence is 0xA,0x5,0xC,0x3;
  - 16 SCK rising edges;
  - frame length is 140 cycles.
- MOSI check: tx_nibble=0x6 → every nibble shows MOSI bits 0,1,1,0 at SCK rises; MOSI=0 during gap slots.
- Start while busy: pulse start again at cycle 50 → no effect; the frame completes normally; a start issued during RECOVER is also ignored.
- Reset mid-frame: assert rst after the second rx_valid → SSEL=1 next cycle, no done pulse, rx_count=0; a new start then yields 0xF first.
